// File: rtl/parity_rx_pkg.sv
// rtl/parity_rx_pkg.sv - FSM encoding, word layout and parity helper for parity_rx_sched
package parity_rx_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_OUT   = 2'd2;

    localparam int WORD_W  = 9;
    localparam int PAR_BIT = 8;

    // Even parity over data plus parity bit; 1 means the word is corrupt.
    function automatic logic parity9(input logic [WORD_W-1:0] word);
        return (^word[PAR_BIT-1:0]) ^ word[PAR_BIT];
    endfunction

endpackage

// File: rtl/parity_rx_sched_rr_arbiter.sv
// rtl/parity_rx_sched_rr_arbiter.sv - combinational round-robin picker, search starts after ptr
module rr_arbiter #(
    parameter int NUM_CH = 4,
    localparam int IDX_W = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              any
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        // ptr itself is visited last, so the previous winner has lowest priority.
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = IDX_W'((int'(ptr) + k) % NUM_CH);
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant_idx  = idx;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parity_rx_sched.sv
// rtl/parity_rx_sched.sv - shared parity-check stage for NUM_CH receive channels
// Optional macro PARITY_RX_DROP_ERR_EN: discard words with bad parity instead of presenting them.
module parity_rx_sched
    import parity_rx_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int ERR_CNT_W = 8,
    localparam int IDX_W    = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic [NUM_CH-1:0]        req_valid,
    input  logic [WORD_W*NUM_CH-1:0] req_data,
    output logic [NUM_CH-1:0]        req_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_byte,
    output logic [IDX_W-1:0]         out_ch,
    output logic                     out_err,
    input  logic                     err_clr,
    output logic [ERR_CNT_W-1:0]     err_cnt
);

    logic [1:0]        state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  cap_ch;
    logic [WORD_W-1:0] cap_word;
    logic [WORD_W-1:0] sel_word;
    logic [NUM_CH-1:0] grant;
    logic [IDX_W-1:0]  grant_idx;
    logic              any;
    logic              perr;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) sel_word = req_data[i*WORD_W +: WORD_W];
        end
    end

    assign req_ready = (state == ST_IDLE) ? grant : '0;
    assign perr      = parity9(cap_word);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state     <= ST_IDLE;
            ptr       <= IDX_W'(NUM_CH - 1);
            cap_word  <= '0;
            cap_ch    <= '0;
            out_valid <= 1'b0;
            out_byte  <= '0;
            out_ch    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        cap_word <= sel_word;
                        cap_ch   <= grant_idx;
                        ptr      <= grant_idx;
                        state    <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    out_byte <= cap_word[7:0];
                    out_ch   <= cap_ch;
`ifdef PARITY_RX_DROP_ERR_EN
                    if (perr) begin
                        state <= ST_IDLE;
                    end else begin
                        out_valid <= 1'b1;
                        state     <= ST_OUT;
                    end
`else
                    out_valid <= 1'b1;
                    state     <= ST_OUT;
`endif
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef PARITY_RX_DROP_ERR_EN
    assign out_err = 1'b0;
`else
    logic out_err_r;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            out_err_r <= 1'b0;
        end else if (state == ST_CHECK) begin
            out_err_r <= perr;
        end
    end

    assign out_err = out_err_r;
`endif

    // Clear has priority over a same-cycle increment.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if ((state == ST_CHECK) && perr && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_parity_rx_sched.sv
// tb/tb_parity_rx_sched.sv - directed self-checking bench for parity_rx_sched
module tb_parity_rx_sched;

    localparam int NUM_CH    = 4;
    localparam int ERR_CNT_W = 2;
`ifdef PARITY_RX_DROP_ERR_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 arst;
    logic [NUM_CH-1:0]    req_valid;
    logic [9*NUM_CH-1:0]  req_data;
    logic [NUM_CH-1:0]    req_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [7:0]           out_byte;
    logic [1:0]           out_ch;
    logic                 out_err;
    logic                 err_clr;
    logic [ERR_CNT_W-1:0] err_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    parity_rx_sched #(.NUM_CH(NUM_CH), .ERR_CNT_W(ERR_CNT_W)) dut (
        .clk       (clk),
        .arst      (arst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_ch    (out_ch),
        .out_err   (out_err),
        .err_clr   (err_clr),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        arst = 1'b0;
        exp_cnt = 0;
    endtask

    // One word from a single requester, out_ready held high.
    task automatic run_one(input int ch, input logic [8:0] w, input bit clr_at_check);
        logic exp_vld;
        @(posedge clk); #1;
        req_valid = 4'(1 << ch);
        req_data[9*ch +: 9] = w;
        @(negedge clk);
        check_val("grant", 32'(req_ready), 32'(1 << ch));
        @(posedge clk); #1;
        req_valid = '0;
        err_clr = clr_at_check;
        @(negedge clk);
        check_val("check_vld", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        err_clr = 1'b0;
        if (clr_at_check) exp_cnt = 0;
        else if ((^w) && exp_cnt < 3) exp_cnt++;
        exp_vld = !(DROP && (^w));
        @(negedge clk);
        check_val("out_vld", 32'(out_valid), 32'(exp_vld));
        if (exp_vld)
            check_val("out_word", 32'({out_err, out_ch, out_byte}),
                      32'({(^w) & !DROP, 2'(ch), w[7:0]}));
        check_val("err_cnt", 32'(err_cnt), 32'(exp_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        arst      = 1'b1;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b1;
        err_clr   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_out", 32'({out_valid, out_err, out_ch, out_byte}), 32'd0);
        check_val("rst_cnt", 32'(err_cnt), 32'd0);
        check_val("rst_ready", 32'(req_ready), 32'd0);
        arst = 1'b0;

        // clean word, then parity error word
        run_one(2, 9'h0A5, 1'b0);
        run_one(0, 9'h1A5, 1'b0);

        // round robin with all four requesting
        do_reset();
        @(posedge clk); #1;
        for (int c = 0; c < NUM_CH; c++) req_data[9*c +: 9] = {1'b0, 8'(8'h11 * c)};
        req_valid = 4'hF;
        for (int g = 0; g < 6; g++) begin
            @(negedge clk);
            for (int k = 0; k < 8 && req_ready == '0; k++) @(negedge clk);
            check_val("rr_grant", 32'(req_ready), 32'(1 << (g % 4)));
            @(negedge clk);
            @(negedge clk);
            b = 8'(8'h11 * (g % 4));
            check_val("rr_out", 32'({out_valid, out_ch, out_byte}), 32'({1'b1, 2'(g % 4), b}));
        end
        @(posedge clk); #1;
        req_valid = '0;

        // backpressure: ch3 held in OUT, ch0 waits
        @(posedge clk); #1;
        out_ready = 1'b0;
        req_data[27 +: 9] = 9'h101;
        req_data[0 +: 9]  = 9'h0A5;
        req_valid = 4'b1000;
        @(negedge clk);
        check_val("bp_grant", 32'(req_ready), 32'b1000);
        @(posedge clk); #1;
        req_valid = 4'b0001;
        @(negedge clk);
        check_val("bp_check_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("bp_hold", 32'({out_valid, out_err, out_ch, out_byte, req_ready}),
                      32'({1'b1, 1'b0, 2'd3, 8'h01, 4'b0000}));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check_val("bp_release", 32'({out_valid, req_ready}), 32'({1'b1, 4'b0000}));
        @(negedge clk);
        check_val("bp_idle", 32'({out_valid, req_ready}), 32'({1'b0, 4'b0001}));
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk);
        @(negedge clk);
        check_val("bp_next", 32'({out_valid, out_ch, out_byte}), 32'({1'b1, 2'd0, 8'hA5}));

        // saturation at 3 with a 2-bit counter
        for (int i = 0; i < 5; i++) run_one(i % 4, 9'h1A5, 1'b0);

        // standalone clear, then clear coincident with an increment
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        check_val("clr_alone", 32'(err_cnt), 32'd0);
        run_one(1, 9'h1A5, 1'b0);
        run_one(2, 9'h1A5, 1'b1);

        // async reset while a word is in CHECK
        run_one(0, 9'h1A5, 1'b0);
        @(posedge clk); #1;
        req_data[9 +: 9] = 9'h1A5;
        req_valid = 4'b0010;
        @(posedge clk); #1;
        req_valid = '0;
        #2;
        arst = 1'b1;
        exp_cnt = 0;
        #1;
        check_val("mid_rst", 32'({out_valid, err_cnt}), 32'd0);
        @(negedge clk);
        arst = 1'b0;
        @(posedge clk); #1;
        req_data[9 +: 9]  = 9'h011;
        req_data[27 +: 9] = 9'h033;
        req_valid = 4'b1010;
        @(negedge clk);
        check_val("post_rst_grant", 32'({out_valid, req_ready}), 32'({1'b0, 4'b0010}));
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk);
        @(negedge clk);
        check_val("post_rst_out", 32'({out_valid, out_ch, out_byte, err_cnt}),
                  32'({1'b1, 2'd1, 8'h11, 2'd0}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/parity_rx_sched.md
Name: parity_rx_sched

Overview:
Round-robin scheduler that shares one parity-check stage among NUM_CH receive channels. Each channel presents 9-bit words: data[7:0] plus parity bit [8]. The block grants one channel at a time, captures the word and checks even parity. It then presents the byte with channel tag and error flag on a valid/ready output, and keeps a saturating error counter. It sits between the per-channel deserializers and the byte sink / host interface.

Parameters:
- NUM_CH, 4, number of requesting channels; legal range 2..16.
- ERR_CNT_W, 8, width of the saturating parity-error counter.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- arst, input, 1, reset, asynchronous, active-high.
- req_valid, input, NUM_CH, per-channel word valid.
- req_data, input, 9*NUM_CH, channel i word at [9*i+8 : 9*i]; bit 9*i+8 is parity.
- req_ready, output, NUM_CH, one-hot grant/accept; combinational.
- out_valid, output, 1, result valid.
- out_ready, input, 1, sink accepts the result.
- out_byte, output, 8, captured data[7:0].
- out_ch, output, $clog2(NUM_CH), source channel index.
- out_err, output, 1, parity error on this word.
- err_clr, input, 1, synchronous clear of err_cnt.
- err_cnt, output, ERR_CNT_W, saturating count of parity errors.

Behaviour:
- Reset (async assert):
  - state=IDLE; out_valid=0, out_byte=0, out_ch=0, out_err=0, err_cnt=0.
  - Capture register is cleared.
  - rr pointer is set to NUM_CH-1, so channel 0 has first priority.
  - Any in-flight word is discarded.
- FSM states: IDLE, CHECK, OUT.
- IDLE:
  - If any req_valid is set, pick the winner by round-robin: search from ptr+1, wrapping modulo NUM_CH.
  - req_ready[winner]=1 in the same cycle; all other ready bits are 0.
  - At the edge: capture the 9-bit word and the channel index, set ptr=winner, go to CHECK.
  - With no valid requests, stay in IDLE and req_ready=0.
- CHECK:
  - req_ready=0.
  - perr = XOR of all 9 captured bits; perr=1 means error.
  - At the edge: register out_byte=word[7:0], out_ch, out_err=perr, set out_valid=1, go to OUT.
  - If perr=1, err_cnt increments unless it is at all-ones; it saturates.
- OUT:
  - req_ready=0.
  - Hold out_* stable while out_ready=0.
  - On out_valid&&out_ready: clear out_valid at the edge and go to IDLE.
- Timing:
  - Acceptance in cycle T gives out_valid in T+2.
  - Maximum throughput is 1 word per 3 cycles.
  - Fairness: a continuously requesting channel is served at least once every NUM_CH grants.
- Input rules:
  - A requester must hold its word while req_valid=1 and it is not granted.
  - A word whose req_valid drops before grant is never captured.
- err_clr:
  - Sets err_cnt=0 on the next edge.
  - Coincident with an increment: clear wins and the result is 0.
  - err_clr has no effect on the FSM.
- err_cnt changes only at the CHECK edge or on err_clr.

Optional Feature:
Macro PARITY_RX_DROP_ERR_EN.
- Defined: a word with perr=1 is not presented. CHECK goes directly to IDLE with out_valid held at 0. err_cnt still increments. out_err is tied to 0.
- Undefined: error words are delivered with out_err=1 and out_byte=data[7:0], exactly as described above.

Decomposition:
- Package parity_rx_pkg holds:
  - state encoding (IDLE=2'd0, CHECK=2'd1, OUT=2'd2);
  - WORD_W=9 and PAR_BIT=8;
  - a parity function (9-bit XOR reduce).
- Sub-module rr_arbiter (NUM_CH):
  - Inputs: req vector, ptr. Outputs: one-hot grant, grant index, any.
  - Purely combinational.
  - The ptr register lives in the parent.

Test Plan:
- Single clean word: reset, ch2 valid with 9'h0A5 (even parity, 4 ones in 0xA5, bit8=0), out_ready=1 -> req_ready=4'b0100 at T; out_valid at T+2 with out_byte=8'hA5, out_ch=2, out_err=0; err_cnt=0.
- Parity error: ch0 sends 9'h1A5 -> out_err=1, out_byte=8'hA5, err_cnt=1. With PARITY_RX_DROP_ERR_EN defined: out_valid never rises and err_cnt=1.
- Round-robin: all four channels valid continuously -> grant order 0,1,2,3,0,1; no channel is granted twice before the others are each served once.
- Backpressure: out_ready=0 for 5 cycles in OUT -> out_byte/out_ch/out_err stay stable, req_ready=0 throughout; release -> IDLE next cycle, then the next grant.
- Saturation and clear: ERR_CNT_W=2, send 5 bad words -> err_cnt sticks at 3. err_clr coincident with a bad word's CHECK edge -> err_cnt=0.
- Reset mid-operation: assert arst during CHECK -> out_valid=0 and err_cnt=0 immediately. After release, a ch1 and ch3 request pair is granted ch1 first (ptr reset).
